// File: rtl/halut_pkg.sv
// Shared widths, command record and FSM state type for the HALUT decoder-side sequencer.
// Default geometry: 32 codebooks of 16 prototypes, 32 output columns over 16 decoder units.
package halut_pkg;

    localparam int unsigned C            = 32;
    localparam int unsigned K            = 16;
    localparam int unsigned M            = 32;
    localparam int unsigned DecoderUnits = 16;
    localparam int unsigned ColsPerUnit  = M / DecoderUnits;

    // Index width that never collapses to zero bits for a dimension of size 1.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CIdxWidth   = idx_width(C);
    localparam int unsigned KIdxWidth   = idx_width(K);
    localparam int unsigned ColIdxWidth = idx_width(ColsPerUnit);

    typedef struct packed {
        logic [CIdxWidth-1:0]   c;
        logic [KIdxWidth-1:0]   k;
        logic [ColIdxWidth-1:0] col;
        logic                   first;
        logic                   last;
    } dec_cmd_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } sched_state_e;

endpackage

// File: rtl/halut_index_buffer.sv
// Two-bank register file holding one encoded row per bank, with full flags,
// the encoder-side write pointer and a combinational read port for the issuer.
module halut_index_buffer
    import halut_pkg::*;
#(
    parameter int unsigned C  = 32,
    parameter int unsigned KW = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    wr_valid,
    input  logic [KW-1:0]           wr_k,
    output logic                    wr_ready,
    output logic                    wr_done,
    input  logic                    rd_free,
    input  logic [idx_width(C)-1:0] rd_c,
    output logic [KW-1:0]           rd_k,
    output logic                    rd_full,
    output logic                    other_full,
    output logic                    any_full
);

    localparam int unsigned CW = idx_width(C);

    logic          wr_bank_reg;
    logic          rd_bank_reg;
    logic [CW-1:0] wr_c_reg;
    logic [1:0]    full_reg;
    logic [1:0]    full_next;
    logic          wr_en;
    logic [KW-1:0] bank_k [2];

    // Ready looks only at registered flags, so a bank freed this cycle takes data next cycle.
    assign wr_ready   = !full_reg[wr_bank_reg];
    assign wr_en      = wr_valid && wr_ready;
    assign wr_done    = wr_en && (wr_c_reg == CW'(C - 1));
    assign rd_full    = full_reg[rd_bank_reg];
    assign other_full = full_reg[!rd_bank_reg];
    assign any_full   = |full_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [KW-1:0] mem [C];

        always_ff @(posedge clk_i) begin
            if (wr_en && (wr_bank_reg == 1'(gi))) begin
                mem[wr_c_reg] <= wr_k;
            end
        end

        assign bank_k[gi] = mem[rd_c];
    end

    assign rd_k = bank_k[rd_bank_reg];

    // Completing one bank and freeing the other in the same cycle are both applied.
    always_comb begin
        full_next = full_reg;
        if (wr_done) begin
            full_next[wr_bank_reg] = 1'b1;
        end
        if (rd_free) begin
            full_next[rd_bank_reg] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_bank_reg <= 1'b0;
            rd_bank_reg <= 1'b0;
            wr_c_reg    <= '0;
            full_reg    <= '0;
        end else if (clear_i) begin
            wr_bank_reg <= 1'b0;
            rd_bank_reg <= 1'b0;
            wr_c_reg    <= '0;
            full_reg    <= '0;
        end else begin
            if (wr_en) begin
                if (wr_done) begin
                    wr_c_reg    <= '0;
                    wr_bank_reg <= !wr_bank_reg;
                end else begin
                    wr_c_reg <= wr_c_reg + CW'(1);
                end
            end
            if (rd_free) begin
                rd_bank_reg <= !rd_bank_reg;
            end
            full_reg <= full_next;
        end
    end

endmodule

// File: rtl/halut_decoder_scheduler.sv
// Sequencer between the HALUT encoder and the decoder-unit array: buffers encoded rows
// and broadcasts C x ColsPerUnit lookup commands per row with accumulator markers.
module halut_decoder_scheduler
    import halut_pkg::*;
#(
    parameter int unsigned C            = halut_pkg::C,
    parameter int unsigned K            = halut_pkg::K,
    parameter int unsigned M            = halut_pkg::M,
    parameter int unsigned DecoderUnits = halut_pkg::DecoderUnits
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      clear_i,
    input  logic                                      enc_valid_i,
    output logic                                      enc_ready_o,
    input  logic [idx_width(K)-1:0]                   enc_k_i,
    output logic                                      dec_valid_o,
    input  logic                                      dec_ready_i,
    output logic [idx_width(C)-1:0]                   dec_c_o,
    output logic [idx_width(K)-1:0]                   dec_k_o,
    output logic [idx_width(M / DecoderUnits)-1:0]    dec_col_o,
    output logic                                      dec_first_o,
    output logic                                      dec_last_o,
    output logic                                      row_done_o,
    output logic [15:0]                               row_cnt_o,
    output logic                                      busy_o
);

    localparam int unsigned Cols = M / DecoderUnits;
    localparam int unsigned CW   = idx_width(C);
    localparam int unsigned KW   = idx_width(K);
    localparam int unsigned ColW = idx_width(Cols);

    if ((M % DecoderUnits) != 0) begin : g_bad_cfg
        $error("halut_decoder_scheduler: M must be a multiple of DecoderUnits");
    end

    sched_state_e    state_reg, state_next;
    logic [CW-1:0]   c_cnt_reg, c_cnt_next;
    logic [ColW-1:0] col_cnt_reg, col_cnt_next;
    logic            row_done_reg;
    logic [15:0]     row_cnt_reg;

    logic            issuing;
    logic            handshake;
    logic            c_last;
    logic            col_last;
    logic            row_end;
    logic            wr_ready;
    logic            wr_done;
    logic            rd_full;
    logic            other_full;
    logic            any_full;
    logic [KW-1:0]   rd_k;

    halut_index_buffer #(
        .C  (C),
        .KW (KW)
    ) u_buffer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .wr_valid   (enc_valid_i),
        .wr_k       (enc_k_i),
        .wr_ready   (wr_ready),
        .wr_done    (wr_done),
        .rd_free    (row_end),
        .rd_c       (c_cnt_reg),
        .rd_k       (rd_k),
        .rd_full    (rd_full),
        .other_full (other_full),
        .any_full   (any_full)
    );

    assign issuing   = (state_reg == ST_ISSUE);
    assign handshake = issuing && dec_ready_i;
    assign c_last    = (c_cnt_reg == CW'(C - 1));
    assign col_last  = (col_cnt_reg == ColW'(Cols - 1));
    assign row_end   = handshake && c_last && col_last;

    // A bank completing this cycle counts as full, so issue starts the cycle after the
    // last index and the next row follows the previous one without a bubble.
    always_comb begin
        state_next   = state_reg;
        c_cnt_next   = c_cnt_reg;
        col_cnt_next = col_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (rd_full || wr_done) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (handshake) begin
                    if (c_last) begin
                        c_cnt_next   = '0;
                        col_cnt_next = col_last ? '0 : col_cnt_reg + ColW'(1);
                    end else begin
                        c_cnt_next = c_cnt_reg + CW'(1);
                    end
                end
                if (row_end && !(other_full || wr_done)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= ST_IDLE;
            c_cnt_reg    <= '0;
            col_cnt_reg  <= '0;
            row_done_reg <= 1'b0;
            row_cnt_reg  <= '0;
        end else if (clear_i) begin
            state_reg    <= ST_IDLE;
            c_cnt_reg    <= '0;
            col_cnt_reg  <= '0;
            row_done_reg <= 1'b0;
            row_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            c_cnt_reg    <= c_cnt_next;
            col_cnt_reg  <= col_cnt_next;
            row_done_reg <= row_end;
            row_cnt_reg  <= row_cnt_reg + 16'(row_end);
        end
    end

    // Payload is gated by the state so idle outputs sit at their reset values.
    assign enc_ready_o = wr_ready;
    assign dec_valid_o = issuing;
    assign dec_c_o     = c_cnt_reg;
    assign dec_col_o   = col_cnt_reg;
    assign dec_k_o     = issuing ? rd_k : '0;
    assign dec_first_o = issuing && (c_cnt_reg == '0);
    assign dec_last_o  = issuing && c_last;
    assign row_done_o  = row_done_reg;
    assign row_cnt_o   = row_cnt_reg;
    assign busy_o      = any_full || issuing;

endmodule

// File: doc/halut_decoder_scheduler.md
# halut_decoder_scheduler

Sequencer between the HALUT encoder and the decoder-unit array. It buffers one encoded row of C prototype indices (K=16, so 4 bit each) per bank, double-buffered. For each buffered row it issues C×ColsPerUnit lookup commands, broadcast in lockstep to all DecoderUnits decoder units, so that every unit covers its ColsPerUnit = M/DecoderUnits output columns. It also generates the accumulator first/last markers and row-completion status.

## Interface
Parameters:
- C, default halut_pkg::C (32): codebooks per row.
- K, default halut_pkg::K (16): prototypes per codebook.
- M, default halut_pkg::M (32): output columns.
- DecoderUnits, default halut_pkg::DecoderUnits (16): number of parallel decoder units; M % DecoderUnits must be 0 (elaboration assertion).

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: reset. One clock; asynchronous, active-low.
- clear_i, in, 1: synchronous flush of buffers, counters and FSM.
- enc_valid_i, in, 1: encoder index valid.
- enc_ready_o, out, 1: buffer can accept an index.
- enc_k_i, in, $clog2(K): prototype index for the next codebook, in codebook order 0..C-1.
- dec_valid_o, out, 1: lookup command valid.
- dec_ready_i, in, 1: AND of all decoder-unit readies.
- dec_c_o, out, $clog2(C): codebook index.
- dec_k_o, out, $clog2(K): prototype index read from the buffer.
- dec_col_o, out, $clog2(ColsPerUnit) (min 1): column within each unit.
- dec_first_o, out, 1: first lookup of a column (clear the accumulator).
- dec_last_o, out, 1: last lookup of a column (emit the result).
- row_done_o, out, 1: one-cycle pulse when a row is fully issued.
- row_cnt_o, out, 16: completed-row counter, wraps at 2^16.
- busy_o, out, 1: any bank is full or the FSM is not IDLE.

## Operation
- Buffer: 2 banks × C × $clog2(K) bits, with per-bank full flags and wr_bank/rd_bank pointers.
- Write side:
  - An accepted index (enc_valid_i && enc_ready_o) is written to [wr_bank][wr_c], and wr_c increments.
  - When wr_c == C-1 is accepted: set full[wr_bank], toggle wr_bank, wr_c ← 0.
  - enc_ready_o = !full[wr_bank], computed from registers only (no same-cycle bypass).
- FSM, two states:
  - IDLE → ISSUE when full[rd_bank].
  - In ISSUE: dec_valid_o = 1. dec_c_o = c_cnt, dec_col_o = col_cnt, dec_k_o = buf[rd_bank][c_cnt].
  - dec_first_o = (c_cnt == 0); dec_last_o = (c_cnt == C-1).
  - Counters advance only on a handshake. c_cnt wraps at C-1 and then increments col_cnt.
- Row end: on a handshake with c_cnt == C-1 && col_cnt == ColsPerUnit-1:
  - clear full[rd_bank], toggle rd_bank, zero both counters;
  - pulse row_done_o the next cycle and increment row_cnt_o;
  - stay in ISSUE if the other bank is already full, else go to IDLE.
- Simultaneous events:
  - A write completing one bank and a read freeing the other in the same cycle are both applied.
  - A bank freed in cycle t accepts writes from t+1.
- clear_i has priority over all updates:
  - bank contents are don't-care; flags, pointers and counters go to zero; FSM → IDLE;
  - row_cnt_o is cleared; no row_done_o pulse is generated.
- Reset mid-row has the same effect as clear_i, applied asynchronously.
- dec_valid_o must stay high and its payload stable while dec_ready_i is low.
- C == 1: dec_first_o and dec_last_o are asserted together.

## Timing
- Reset values: enc_ready_o = 1; dec_valid_o, dec_first_o, dec_last_o, row_done_o, busy_o = 0; dec_c_o, dec_k_o, dec_col_o = 0; row_cnt_o = 0.
- Last index of a row accepted at cycle t → dec_valid_o high at t+1.
- With no stalls a row issues in C×ColsPerUnit cycles (64 with defaults). The last issue of the row is at cycle t+1+C×ColsPerUnit-1.
- row_done_o pulses one cycle after the row's final handshake.
- Back-to-back full banks issue with zero idle cycles between rows.
- Encoder throughput is bounded by the issue rate: the encoder stalls once both banks are full.

## Structure
- Add to halut_pkg:
  - localparams ColsPerUnit = M/DecoderUnits, CIdxWidth = $clog2(C), KIdxWidth = $clog2(K), ColIdxWidth;
  - typedef struct packed dec_cmd_t {c, k, col, first, last}.
- Sub-module halut_index_buffer: two-bank register file with full flags, write pointer and read port. The FSM and counters stay in the top module.

## Test plan
- Single row, defaults: feed k = c mod 16 for c = 0..31, dec_ready_i = 1.
  - Expect 64 commands, col 0 then col 1, each with k matching its c.
  - dec_first_o at c = 0 and dec_last_o at c = 31 in each column.
  - One row_done_o pulse; row_cnt_o = 1.
- Back-to-back: stream 3 rows continuously.
  - enc_ready_o drops after 2 rows are buffered.
  - 192 consecutive valid cycles with no bubble between rows; row_cnt_o = 3.
- Backpressure: random dec_ready_i at 30% duty.
  - Payload stays stable while stalled.
  - The command sequence is identical to the unstalled run.
- Bank handoff: the last issue of bank 0 coincides with the last write into bank 1 in the same cycle.
  - Issue continues from bank 1 the next cycle.
  - Bank 0 accepts a write the following cycle.
- clear_i at command 20 of a row, with the second bank full.
  - Next cycle: dec_valid_o = 0, busy_o = 0, row_cnt_o = 0.
  - A new row issues from c = 0, col = 0.
- rst_ni asserted mid-issue: all outputs take their reset values immediately (asynchronously).
